// File: rtl/ct_lsu_snoop_ctcq_inv_issue.sv
// Snoop CTC queue consumer: round-robin grants one pending entry, issues its
// icache/TLB invalidation, waits for the target unit's done and pulses completion.
module ct_lsu_snoop_ctcq_inv_issue #(
   parameter int ENTRY_NUM = 4,
   parameter int PA_WIDTH  = 40,
   parameter int VA_WIDTH  = 39
) (
   input  logic                            lsu_snoop_clk,
   input  logic                            cpurst_b,
   input  logic [ENTRY_NUM-1:0]            ctcq_pe_req,
   input  logic [6*ENTRY_NUM-1:0]          ctcq_type_flags,
   input  logic [6*ENTRY_NUM-1:0]          ctcq_icache_index,
   input  logic [(PA_WIDTH-12)*ENTRY_NUM-1:0] ctcq_icache_ptag,
   input  logic [16*ENTRY_NUM-1:0]         ctcq_tlb_asid,
   input  logic [(VA_WIDTH-12)*ENTRY_NUM-1:0] ctcq_tlb_va,
   input  logic                            ifu_lsu_icache_inv_done,
   input  logic                            mmu_lsu_tlb_inv_done,
   output logic                            lsu_ifu_icache_all_inv,
   output logic                            lsu_ifu_icache_line_inv,
   output logic [5:0]                      lsu_ifu_icache_index,
   output logic [PA_WIDTH-13:0]            lsu_ifu_icache_ptag,
   output logic                            lsu_mmu_tlb_all_inv,
   output logic                            lsu_mmu_tlb_va_all_inv,
   output logic                            lsu_mmu_tlb_asid_all_inv,
   output logic                            lsu_mmu_tlb_va_asid_inv,
   output logic [15:0]                     lsu_mmu_tlb_asid,
   output logic [VA_WIDTH-13:0]            lsu_mmu_tlb_va,
   output logic [ENTRY_NUM-1:0]            ica_tlb_ctcq_inv_cmplt_x,
   output logic                            ctcq_issue_busy,
   output logic [1:0]                      ctcq_issue_state_dbg
);

   localparam int PTAG_W = PA_WIDTH - 12;
   localparam int TVA_W  = VA_WIDTH - 12;
   localparam int PTR_W  = $clog2(ENTRY_NUM);
   localparam logic [PTR_W:0]   N_WIDE = (PTR_W+1)'(ENTRY_NUM);
   localparam logic [PTR_W-1:0] LAST   = PTR_W'(ENTRY_NUM - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   state_e                  state_q, state_d;
   logic [PTR_W-1:0]        rr_ptr_q, rr_ptr_d;
   logic [PTR_W-1:0]        grant_q, grant_d;
   logic [5:0]              type_q, type_d;
   logic [5:0]              index_q, index_d;
   logic [PTAG_W-1:0]       ptag_q, ptag_d;
   logic [15:0]             asid_q, asid_d;
   logic [TVA_W-1:0]        va_q, va_d;
   logic [5:0]              req_q, req_d;
   logic [5:0]              out_index_q, out_index_d;
   logic [PTAG_W-1:0]       out_ptag_q, out_ptag_d;
   logic [15:0]             out_asid_q, out_asid_d;
   logic [TVA_W-1:0]        out_va_q, out_va_d;
   logic [ENTRY_NUM-1:0]    cmplt_q, cmplt_d;

   logic                    found;
   logic [PTR_W-1:0]        pick;
   logic [PTR_W:0]          idx;
   logic [5:0]              sel_type;
   logic [5:0]              sel_index;
   logic [PTAG_W-1:0]       sel_ptag;
   logic [15:0]             sel_asid;
   logic [TVA_W-1:0]        sel_va;
   logic                    tgt_done;

   // Illegal multi-flag types collapse to the highest flag: icache before tlb.
   function automatic logic [5:0] prio_type(input logic [5:0] f);
      logic [5:0] r;
      r = 6'b0;
      casez (f)
         6'b1?????: r = 6'b100000;
         6'b01????: r = 6'b010000;
         6'b001???: r = 6'b001000;
         6'b0001??: r = 6'b000100;
         6'b00001?: r = 6'b000010;
         6'b000001: r = 6'b000001;
         default:   r = 6'b000000;
      endcase
      return r;
   endfunction

   // Round-robin search starting at rr_ptr, wrapping at ENTRY_NUM-1.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      idx   = '0;
      for (int k = 0; k < ENTRY_NUM; k++) begin
         idx = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
         if (idx >= N_WIDE) idx = idx - N_WIDE;
         if (!found && ctcq_pe_req[idx[PTR_W-1:0]]) begin
            found = 1'b1;
            pick  = idx[PTR_W-1:0];
         end
      end
   end

   always_comb begin
      sel_type  = '0;
      sel_index = '0;
      sel_ptag  = '0;
      sel_asid  = '0;
      sel_va    = '0;
      for (int e = 0; e < ENTRY_NUM; e++) begin
         if (pick == PTR_W'(e)) begin
            sel_type  = ctcq_type_flags[6*e +: 6];
            sel_index = ctcq_icache_index[6*e +: 6];
            sel_ptag  = ctcq_icache_ptag[PTAG_W*e +: PTAG_W];
            sel_asid  = ctcq_tlb_asid[16*e +: 16];
            sel_va    = ctcq_tlb_va[TVA_W*e +: TVA_W];
         end
      end
   end

   // Requests are levels held through ISSUE; each unit answers with a one-cycle
   // done pulse, and only the done of the unit actually targeted is honoured.
   assign tgt_done = (|type_q[5:4]) ? ifu_lsu_icache_inv_done : mmu_lsu_tlb_inv_done;

   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      grant_d     = grant_q;
      type_d      = type_q;
      index_d     = index_q;
      ptag_d      = ptag_q;
      asid_d      = asid_q;
      va_d        = va_q;
      req_d       = '0;
      out_index_d = '0;
      out_ptag_d  = '0;
      out_asid_d  = '0;
      out_va_d    = '0;
      cmplt_d     = '0;

      case (state_q)
         ST_IDLE: begin
            if (found) begin
               grant_d = pick;
               type_d  = sel_type;
               index_d = sel_index;
               ptag_d  = sel_ptag;
               asid_d  = sel_asid;
               va_d    = sel_va;
               state_d = (sel_type == 6'b0) ? ST_DONE : ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (tgt_done) state_d = ST_DONE;
         end
         ST_DONE: begin
            rr_ptr_d = (grant_q == LAST) ? '0 : grant_q + 1'b1;
            state_d  = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      if (state_d == ST_ISSUE) begin
         req_d       = prio_type(type_d);
         out_index_d = index_d;
         out_ptag_d  = ptag_d;
         out_asid_d  = asid_d;
         out_va_d    = va_d;
      end
      if (state_d == ST_DONE) cmplt_d[grant_d] = 1'b1;
   end

   always_ff @(posedge lsu_snoop_clk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         state_q     <= ST_IDLE;
         rr_ptr_q    <= '0;
         grant_q     <= '0;
         type_q      <= '0;
         index_q     <= '0;
         ptag_q      <= '0;
         asid_q      <= '0;
         va_q        <= '0;
         req_q       <= '0;
         out_index_q <= '0;
         out_ptag_q  <= '0;
         out_asid_q  <= '0;
         out_va_q    <= '0;
         cmplt_q     <= '0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         grant_q     <= grant_d;
         type_q      <= type_d;
         index_q     <= index_d;
         ptag_q      <= ptag_d;
         asid_q      <= asid_d;
         va_q        <= va_d;
         req_q       <= req_d;
         out_index_q <= out_index_d;
         out_ptag_q  <= out_ptag_d;
         out_asid_q  <= out_asid_d;
         out_va_q    <= out_va_d;
         cmplt_q     <= cmplt_d;
      end
   end

   assign lsu_ifu_icache_all_inv   = req_q[5];
   assign lsu_ifu_icache_line_inv  = req_q[4];
   assign lsu_mmu_tlb_all_inv      = req_q[3];
   assign lsu_mmu_tlb_va_all_inv   = req_q[2];
   assign lsu_mmu_tlb_asid_all_inv = req_q[1];
   assign lsu_mmu_tlb_va_asid_inv  = req_q[0];
   assign lsu_ifu_icache_index     = out_index_q;
   assign lsu_ifu_icache_ptag      = out_ptag_q;
   assign lsu_mmu_tlb_asid         = out_asid_q;
   assign lsu_mmu_tlb_va           = out_va_q;
   assign ica_tlb_ctcq_inv_cmplt_x = cmplt_q;
   assign ctcq_issue_busy          = (state_q != ST_IDLE);
   assign ctcq_issue_state_dbg     = state_q;

endmodule

// File: tb/tb_ct_lsu_snoop_ctcq_inv_issue.sv
// Directed bench for the snoop CTCQ invalidation issuer: vector table for single
// transactions plus hand sequences for round-robin order and mid-flight reset.
module tb_ct_lsu_snoop_ctcq_inv_issue;

   localparam int N      = 4;
   localparam int PTAG_W = 28;
   localparam int TVA_W  = 27;

   logic                  clk = 1'b0;
   logic                  cpurst_b;
   logic [N-1:0]          pe_req;
   logic [6*N-1:0]        type_flags;
   logic [6*N-1:0]        icache_index;
   logic [PTAG_W*N-1:0]   icache_ptag;
   logic [16*N-1:0]       tlb_asid;
   logic [TVA_W*N-1:0]    tlb_va;
   logic                  ifu_done;
   logic                  mmu_done;

   logic                  ica_all, ica_line, tlb_all, tlb_va_all, tlb_asid_all, tlb_va_asid;
   logic [5:0]            o_index;
   logic [PTAG_W-1:0]     o_ptag;
   logic [15:0]           o_asid;
   logic [TVA_W-1:0]      o_va;
   logic [N-1:0]          cmplt;
   logic                  busy;
   logic [1:0]            state_dbg;

   int checks = 0;
   int errors = 0;

   ct_lsu_snoop_ctcq_inv_issue #(.ENTRY_NUM(N), .PA_WIDTH(40), .VA_WIDTH(39)) dut (
      .lsu_snoop_clk            (clk),
      .cpurst_b                 (cpurst_b),
      .ctcq_pe_req              (pe_req),
      .ctcq_type_flags          (type_flags),
      .ctcq_icache_index        (icache_index),
      .ctcq_icache_ptag         (icache_ptag),
      .ctcq_tlb_asid            (tlb_asid),
      .ctcq_tlb_va              (tlb_va),
      .ifu_lsu_icache_inv_done  (ifu_done),
      .mmu_lsu_tlb_inv_done     (mmu_done),
      .lsu_ifu_icache_all_inv   (ica_all),
      .lsu_ifu_icache_line_inv  (ica_line),
      .lsu_ifu_icache_index     (o_index),
      .lsu_ifu_icache_ptag      (o_ptag),
      .lsu_mmu_tlb_all_inv      (tlb_all),
      .lsu_mmu_tlb_va_all_inv   (tlb_va_all),
      .lsu_mmu_tlb_asid_all_inv (tlb_asid_all),
      .lsu_mmu_tlb_va_asid_inv  (tlb_va_asid),
      .lsu_mmu_tlb_asid         (o_asid),
      .lsu_mmu_tlb_va           (o_va),
      .ica_tlb_ctcq_inv_cmplt_x (cmplt),
      .ctcq_issue_busy          (busy),
      .ctcq_issue_state_dbg     (state_dbg)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog expired actual=running required=finished");
      $fatal(1);
   end

   typedef struct {
      int           entry;
      logic [5:0]   flags;
      logic [5:0]   index;
      logic [27:0]  ptag;
      logic [15:0]  asid;
      logic [26:0]  va;
      int           delay;
      logic         wrong_first;
      logic         both_at_done;
      logic [5:0]   exp_req;
   } vec_t;

   vec_t vecs[10];

   function automatic logic [5:0] req_vec();
      return {ica_all, ica_line, tlb_all, tlb_va_all, tlb_asid_all, tlb_va_asid};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic [5:0] er, input logic [5:0] ei,
                          input logic [27:0] ep, input logic [15:0] ea, input logic [26:0] ev,
                          input logic [3:0] ec, input logic eb);
      chk({tag, "_req"},   64'(req_vec()), 64'(er));
      chk({tag, "_index"}, 64'(o_index),   64'(ei));
      chk({tag, "_ptag"},  64'(o_ptag),    64'(ep));
      chk({tag, "_asid"},  64'(o_asid),    64'(ea));
      chk({tag, "_va"},    64'(o_va),      64'(ev));
      chk({tag, "_cmplt"}, 64'(cmplt),     64'(ec));
      chk({tag, "_busy"},  64'(busy),      64'(eb));
   endtask

   // Samples #1 after the edge; the served entry drops pe_req once it sees its pulse.
   task automatic tick();
      @(posedge clk);
      #1;
      if (cmplt != '0) pe_req = pe_req & ~cmplt;
   endtask

   task automatic fill_junk();
      for (int e = 0; e < N; e++) begin
         type_flags[6*e +: 6]          = 6'b000100;
         icache_index[6*e +: 6]        = 6'h3F;
         icache_ptag[PTAG_W*e +: PTAG_W] = '1;
         tlb_asid[16*e +: 16]          = 16'hFFFF;
         tlb_va[TVA_W*e +: TVA_W]      = '1;
      end
   endtask

   task automatic set_entry(input int e, input logic [5:0] f, input logic [5:0] i,
                            input logic [27:0] p, input logic [15:0] a, input logic [26:0] v);
      type_flags[6*e +: 6]            = f;
      icache_index[6*e +: 6]          = i;
      icache_ptag[PTAG_W*e +: PTAG_W] = p;
      tlb_asid[16*e +: 16]            = a;
      tlb_va[TVA_W*e +: TVA_W]        = v;
   endtask

   task automatic do_reset();
      cpurst_b = 1'b0;
      pe_req   = '0;
      ifu_done = 1'b0;
      mmu_done = 1'b0;
      tick();
      tick();
      cpurst_b = 1'b1;
      tick();
   endtask

   task automatic run_vec(input vec_t v, input int n);
      logic [3:0] oh;
      logic       is_ica;
      string      tag;
      oh     = 4'b0001 << v.entry;
      is_ica = |v.exp_req[5:4];
      tag    = $sformatf("vec%0d", n);
      fill_junk();
      set_entry(v.entry, v.flags, v.index, v.ptag, v.asid, v.va);
      pe_req = oh;
      tick();
      if (v.exp_req == 6'b0) begin
         chk_out({tag, "_done"}, 6'b0, 6'b0, 28'b0, 16'b0, 27'b0, oh, 1'b1);
      end else begin
         chk_out({tag, "_issue"}, v.exp_req, v.index, v.ptag, v.asid, v.va, 4'b0, 1'b1);
         if (v.wrong_first) begin
            if (is_ica) mmu_done = 1'b1; else ifu_done = 1'b1;
            tick();
            ifu_done = 1'b0;
            mmu_done = 1'b0;
            chk_out({tag, "_ignore"}, v.exp_req, v.index, v.ptag, v.asid, v.va, 4'b0, 1'b1);
         end
         for (int d = 0; d < v.delay; d++) begin
            tick();
            chk_out({tag, "_hold"}, v.exp_req, v.index, v.ptag, v.asid, v.va, 4'b0, 1'b1);
         end
         if (is_ica || v.both_at_done) ifu_done = 1'b1;
         if (!is_ica || v.both_at_done) mmu_done = 1'b1;
         tick();
         ifu_done = 1'b0;
         mmu_done = 1'b0;
         chk_out({tag, "_done"}, 6'b0, 6'b0, 28'b0, 16'b0, 27'b0, oh, 1'b1);
      end
      tick();
      chk({tag, "_idle_cmplt"}, 64'(cmplt), 64'(0));
      chk({tag, "_idle_busy"},  64'(busy),  64'(0));
   endtask

   initial begin
      vecs[0] = '{entry:0, flags:6'b010000, index:6'h15, ptag:28'h1234567, asid:16'h0,    va:27'h0,       delay:1, wrong_first:1'b0, both_at_done:1'b0, exp_req:6'b010000};
      vecs[1] = '{entry:2, flags:6'b000001, index:6'h2A, ptag:28'h0FEDCBA, asid:16'h00A5, va:27'h1ABCDEF, delay:1, wrong_first:1'b1, both_at_done:1'b1, exp_req:6'b000001};
      vecs[2] = '{entry:2, flags:6'b000000, index:6'h11, ptag:28'h0000111, asid:16'h1111, va:27'h0000111, delay:0, wrong_first:1'b0, both_at_done:1'b0, exp_req:6'b000000};
      vecs[3] = '{entry:1, flags:6'b100000, index:6'h01, ptag:28'h0ABCDEF, asid:16'h2222, va:27'h0002222, delay:0, wrong_first:1'b0, both_at_done:1'b0, exp_req:6'b100000};
      vecs[4] = '{entry:3, flags:6'b001000, index:6'h07, ptag:28'h7654321, asid:16'h3C3C, va:27'h5A5A5A5, delay:2, wrong_first:1'b1, both_at_done:1'b0, exp_req:6'b001000};
      vecs[5] = '{entry:0, flags:6'b000100, index:6'h22, ptag:28'h0000022, asid:16'h0042, va:27'h0042042, delay:0, wrong_first:1'b0, both_at_done:1'b0, exp_req:6'b000100};
      vecs[6] = '{entry:1, flags:6'b000010, index:6'h33, ptag:28'h0000033, asid:16'hBEEF, va:27'h0000BEE, delay:0, wrong_first:1'b0, both_at_done:1'b0, exp_req:6'b000010};
      vecs[7] = '{entry:3, flags:6'b010011, index:6'h0C, ptag:28'h0C0C0C0, asid:16'h0C0C, va:27'h0C0C0C0, delay:0, wrong_first:1'b1, both_at_done:1'b0, exp_req:6'b010000};
      vecs[8] = '{entry:1, flags:6'b000110, index:6'h19, ptag:28'h0191919, asid:16'h1919, va:27'h1919191, delay:0, wrong_first:1'b0, both_at_done:1'b0, exp_req:6'b000100};
      vecs[9] = '{entry:0, flags:6'b110000, index:6'h2E, ptag:28'h2E2E2E2, asid:16'h2E2E, va:27'h2E2E2E2, delay:0, wrong_first:1'b0, both_at_done:1'b0, exp_req:6'b100000};

      cpurst_b = 1'b0;
      pe_req   = '0;
      ifu_done = 1'b0;
      mmu_done = 1'b0;
      fill_junk();
      #2;
      chk_out("reset", 6'b0, 6'b0, 28'b0, 16'b0, 27'b0, 4'b0, 1'b0);
      chk("reset_state", 64'(state_dbg), 64'(0));
      tick();
      tick();
      cpurst_b = 1'b1;
      tick();

      for (int n = 0; n < 10; n++) run_vec(vecs[n], n);

      // All four pending from rr_ptr=0, done returned in the first ISSUE cycle.
      do_reset();
      fill_junk();
      for (int e = 0; e < N; e++)
         set_entry(e, 6'b001000, 6'(e + 8), 28'(e + 28'h100), 16'(16'h1000 + e), 27'(e + 27'h300));
      pe_req = 4'b1111;
      for (int g = 0; g < N; g++) begin
         tick();
         chk($sformatf("rr%0d_asid", g), 64'(o_asid), 64'(16'h1000 + g));
         chk($sformatf("rr%0d_req", g), 64'(req_vec()), 64'(6'b001000));
         mmu_done = 1'b1;
         tick();
         mmu_done = 1'b0;
         chk($sformatf("rr%0d_cmplt", g), 64'(cmplt), 64'(4'b0001 << g));
         tick();
         chk($sformatf("rr%0d_idle", g), 64'(busy), 64'(0));
      end

      // Serve entry 2 (typeless) so rr_ptr lands on 3, then 3 must beat 0.
      fill_junk();
      set_entry(2, 6'b000000, 6'h02, 28'h2, 16'h2, 27'h2);
      pe_req = 4'b0100;
      tick();
      chk("wrap_pre_cmplt", 64'(cmplt), 64'(4'b0100));
      tick();
      set_entry(0, 6'b100000, 6'h01, 28'h10, 16'h10, 27'h10);
      set_entry(3, 6'b100000, 6'h03, 28'h30, 16'h30, 27'h30);
      pe_req = 4'b1001;
      tick();
      chk("wrap_first_index", 64'(o_index), 64'(6'h03));
      ifu_done = 1'b1;
      tick();
      ifu_done = 1'b0;
      chk("wrap_first_cmplt", 64'(cmplt), 64'(4'b1000));
      tick();
      tick();
      chk("wrap_second_index", 64'(o_index), 64'(6'h01));
      ifu_done = 1'b1;
      tick();
      ifu_done = 1'b0;
      chk("wrap_second_cmplt", 64'(cmplt), 64'(4'b0001));
      tick();

      // Reset while ISSUE holds a TLB request: everything clears, no completion.
      fill_junk();
      set_entry(1, 6'b001000, 6'h05, 28'h55, 16'h5555, 27'h555);
      pe_req = 4'b0010;
      tick();
      chk_out("abort_issue", 6'b001000, 6'h05, 28'h55, 16'h5555, 27'h555, 4'b0, 1'b1);
      cpurst_b = 1'b0;
      #1;
      chk_out("abort_rst", 6'b0, 6'b0, 28'b0, 16'b0, 27'b0, 4'b0, 1'b0);
      chk("abort_state", 64'(state_dbg), 64'(0));
      pe_req = '0;
      tick();
      cpurst_b = 1'b1;
      mmu_done = 1'b1;
      tick();
      mmu_done = 1'b0;
      for (int c = 0; c < 3; c++) begin
         chk($sformatf("abort_post%0d_cmplt", c), 64'(cmplt), 64'(0));
         chk($sformatf("abort_post%0d_busy", c), 64'(busy), 64'(0));
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
